// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU background pipeline.
package ppu_pkg;
  typedef enum logic [3:0] {
    IDLE, T_REQ, T_CAP, L_REQ, L_CAP, H_REQ, H_CAP, PUSH, FLUSH_END
  } fetch_state_t;

  localparam logic [12:0] MAP0_BASE        = 13'h1800;
  localparam logic [12:0] MAP1_BASE        = 13'h1C00;
  localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;
  localparam int          TILE_BYTES       = 16;

  typedef logic [1:0] pixel_t;

  // Address of the low bitplane byte for one tile row; all math wraps at 13 bits.
  function automatic logic [12:0] tile_row_addr(input logic [7:0] id, input logic unsigned_sel,
                                                input logic [2:0] fine_y);
    logic [12:0] base;
    base = unsigned_sel ? 13'(id) * 13'(TILE_BYTES)
                        : TILE_SIGNED_BASE + 13'($signed(id)) * 13'(TILE_BYTES);
    return base + {9'b0, fine_y, 1'b0};
  endfunction
endpackage

// File: rtl/bg_pixel_fifo.sv
// Circular pixel buffer: 8-wide push of one decoded tile row, 1-wide pop, sync flush.
module bg_pixel_fifo
  import ppu_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH) + 1,
  localparam int IW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  pixel_t [7:0]  push_data,
  input  logic          pop,
  output pixel_t        head,
  output logic [CW-1:0] count
);
  pixel_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Pointers stay in [0, FIFO_DEPTH); the spare bit absorbs the +8 before the wrap.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input logic [AW-1:0] inc);
    logic [AW-1:0] s;
    s = p + inc;
    return (s >= AW'(FIFO_DEPTH)) ? s - AW'(FIFO_DEPTH) : s;
  endfunction

  always_ff @(posedge clk)
    if (push && !flush)
      for (int i = 0; i < 8; i++) begin
        logic [AW-1:0] wa;
        wa = wrap_add(wr_ptr, AW'(i));
        mem[wa[IW-1:0]] <= push_data[i];
      end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_add(wr_ptr, AW'(8));
      if (pop)  rd_ptr <= wrap_add(rd_ptr, AW'(1));
      count <= count + (push ? CW'(8) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end

  assign head = mem[rd_ptr[IW-1:0]];
endmodule

// File: rtl/ppu_bg_fetcher.sv
// Background tile fetcher: VRAM map/tile reads -> 2-bit pixels -> FIFO -> valid/ready stream.
module ppu_bg_fetcher
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_PIXELS = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ly,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic        bg_map_sel,
  input  logic        tile_data_sel,
  output logic        vram_en,
  output logic [12:0] vram_addr,
  input  logic [7:0]  vram_dout,
  output logic        pix_valid,
  output pixel_t      pix_data,
  input  logic        pix_ready,
  output logic        busy,
  output logic        line_done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(LINE_PIXELS + 1);

  fetch_state_t  state, state_nxt;
  logic [4:0]    row, tile_x;
  logic [2:0]    fine_y, discard;
  logic [OW-1:0] out_cnt;
  logic [7:0]    tile_id, lo, hi, y_sum;
  logic [12:0]   map_base, tile_addr;
  logic [CW-1:0] count;
  pixel_t [7:0]  push_data;
  logic          fifo_empty, accept, drop, last, room, push, pop, flush;

  assign y_sum      = ly + scy;
  assign fifo_empty = (count == '0);
  assign busy       = (state != IDLE);
  assign pix_valid  = busy && !fifo_empty && (discard == '0);
  assign accept     = pix_valid && pix_ready;
  assign drop       = (discard != '0) && !fifo_empty;
  assign last       = accept && (out_cnt == OW'(LINE_PIXELS - 1));
  assign room       = (count <= CW'(FIFO_DEPTH - 8));
  // A restart or the final accept discards everything buffered and anything in flight.
  assign flush      = start || last;
  assign push       = (state == PUSH) && room && !flush;
  assign pop        = accept || drop;
  assign line_done  = (state == FLUSH_END);
  assign map_base   = bg_map_sel ? MAP1_BASE : MAP0_BASE;
  assign tile_addr  = tile_row_addr(tile_id, tile_data_sel, fine_y);

  always_comb
    for (int i = 0; i < 8; i++) push_data[i] = {hi[7-i], lo[7-i]};

  always_comb begin
    state_nxt = state;
    vram_en   = 1'b0;
    vram_addr = '0;
    case (state)
      T_REQ: begin
        vram_en   = 1'b1;
        vram_addr = map_base + {3'b0, row, tile_x};
        state_nxt = T_CAP;
      end
      T_CAP: state_nxt = L_REQ;
      L_REQ: begin
        vram_en   = 1'b1;
        vram_addr = tile_addr;
        state_nxt = L_CAP;
      end
      L_CAP: state_nxt = H_REQ;
      H_REQ: begin
        vram_en   = 1'b1;
        vram_addr = tile_addr + 13'd1;
        state_nxt = H_CAP;
      end
      H_CAP:     state_nxt = PUSH;
      PUSH:      if (room) state_nxt = T_REQ;
      FLUSH_END: state_nxt = IDLE;
      default:   state_nxt = state;
    endcase
    if (last)  state_nxt = FLUSH_END;
    if (start) state_nxt = T_REQ;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      row     <= '0;
      fine_y  <= '0;
      tile_x  <= '0;
      discard <= '0;
      out_cnt <= '0;
      tile_id <= '0;
      lo      <= '0;
      hi      <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        row     <= y_sum[7:3];
        fine_y  <= y_sum[2:0];
        tile_x  <= scx[7:3];
        discard <= scx[2:0];
        out_cnt <= '0;
      end else begin
        if (drop)   discard <= discard - 3'd1;
        if (accept) out_cnt <= out_cnt + OW'(1);
        if (push)   tile_x  <= tile_x + 5'd1;
        case (state)
          T_CAP:   tile_id <= vram_dout;
          L_CAP:   lo      <= vram_dout;
          H_CAP:   hi      <= vram_dout;
          default: ;
        endcase
      end
    end

  bg_pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (pix_data),
    .count    (count)
  );
endmodule
